rv32i_fetch_unit: RTL and testbench

Instruction fetch stage of the RV32I pipeline. It owns the program counter, issues in-order requests to instruction memory over a request/grant/response handshake, and buffers returned words. It presents `pc_out`/`iw_out` to the decode stage and acts on the decode stage's `jump_enable`/`jump_addr` redirect, discarding wrong-path fetches. Bubbles are delivered as NOP (`32'h13`), so decode needs no valid bit.

---
 rtl/rv32i_fetch_unit_if.sv | 10 +
 rtl/rv32i_fetch_unit.sv | 88 ++++++++
 tb/tb_rv32i_fetch_unit.sv | 201 ++++++++++++++++++++
 3 files changed

// File: rtl/rv32i_fetch_unit_if.sv
// rv32i_fetch_unit_if: instruction-memory request/grant/response bus
interface rv32i_fetch_unit_if;
  logic        req;
  logic [31:0] addr;
  logic        gnt;
  logic        rvalid;
  logic [31:0] rdata;
  modport master (output req, addr, input gnt, rvalid, rdata);
  modport slave  (input req, addr, output gnt, rvalid, rdata);
endinterface

// File: rtl/rv32i_fetch_unit.sv
// rv32i_fetch_unit: RV32I fetch stage with credit-limited in-order imem requests and NOP bubbles
module rv32i_fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0,
  parameter int          DEPTH    = 2,
  parameter logic [31:0] NOP      = 32'h13
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               jump_enable,
  input  logic [31:0]        jump_addr,
  input  logic               stall,
  rv32i_fetch_unit_if.master imem,
  output logic [31:0]        pc_out,
  output logic [31:0]        iw_out,
  output logic               misalign_out
);
  localparam int CW = $clog2(DEPTH + 1);
  localparam int IW = $clog2(DEPTH);
  logic [31:0]   fetch_pc;
  logic [31:0]   pend_pc [DEPTH];
  logic [31:0]   buf_pc [DEPTH];
  logic [31:0]   buf_iw [DEPTH];
  logic [CW-1:0] pend_cnt, buf_cnt, kill_cnt;
  logic [CW+1:0] credit;
  logic          grant, rsp_kill, rsp_ok, rsp_any, buf_pop, buf_push;
  logic [IW-1:0] pend_wi, buf_wi;
  // every outstanding, doomed or buffered word holds a credit, so the buffer can never overflow
  always_comb begin
    credit    = (CW+2)'(pend_cnt) + (CW+2)'(kill_cnt) + (CW+2)'(buf_cnt);
    imem.req  = !reset && !jump_enable && credit < (CW+2)'(DEPTH);
    imem.addr = fetch_pc;
    grant     = imem.req && imem.gnt;
    rsp_kill  = imem.rvalid && kill_cnt != '0;
    rsp_ok    = imem.rvalid && kill_cnt == '0 && pend_cnt != '0;
    rsp_any   = rsp_kill || rsp_ok;
    buf_pop   = !jump_enable && !stall && buf_cnt != '0;
    buf_push  = !jump_enable && rsp_ok && (stall || buf_cnt != '0);
    pend_wi   = IW'(pend_cnt - CW'(rsp_ok));
    buf_wi    = IW'(buf_cnt - CW'(buf_pop));
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      fetch_pc <= RESET_PC;
      pend_cnt <= '0;
      buf_cnt  <= '0;
      kill_cnt <= '0;
    end else if (jump_enable) begin
      fetch_pc <= {jump_addr[31:2], 2'b00};
      pend_cnt <= '0;
      buf_cnt  <= '0;
      kill_cnt <= kill_cnt + pend_cnt - CW'(rsp_any);
    end else begin
      fetch_pc <= grant ? fetch_pc + 32'd4 : fetch_pc;
      pend_cnt <= pend_cnt + CW'(grant) - CW'(rsp_ok);
      buf_cnt  <= buf_cnt + CW'(buf_push) - CW'(buf_pop);
      kill_cnt <= kill_cnt - CW'(rsp_kill);
    end
  end
  // head-at-zero shift FIFOs; counters alone define occupancy, so storage needs no reset
  always_ff @(posedge clk) begin
    if (rsp_ok)
      for (int i = 0; i < DEPTH - 1; i++) pend_pc[i] <= pend_pc[i+1];
    if (grant) pend_pc[pend_wi] <= fetch_pc;
    if (buf_pop)
      for (int i = 0; i < DEPTH - 1; i++) begin
        buf_pc[i] <= buf_pc[i+1];
        buf_iw[i] <= buf_iw[i+1];
      end
    if (buf_push) begin
      buf_pc[buf_wi] <= pend_pc[0];
      buf_iw[buf_wi] <= imem.rdata;
    end
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      pc_out       <= RESET_PC;
      iw_out       <= NOP;
      misalign_out <= 1'b0;
    end else begin
      misalign_out <= jump_enable && |jump_addr[1:0];
      if (jump_enable) iw_out <= NOP;
      else if (!stall) begin
        pc_out <= buf_pop ? buf_pc[0] : rsp_ok ? pend_pc[0] : pc_out;
        iw_out <= buf_pop ? buf_iw[0] : rsp_ok ? imem.rdata : NOP;
      end
    end
  end
endmodule

// File: tb/tb_rv32i_fetch_unit.sv
// tb_rv32i_fetch_unit: random memory/decode stimulus against an architectural PC-stream scoreboard
module tb_rv32i_fetch_unit;
  localparam logic [31:0] NOP    = 32'h13;
  localparam logic [31:0] RST_PC = 32'h0;
  logic        clk = 1'b1, reset = 1'b1, jump_enable = 1'b0, stall = 1'b0;
  logic [31:0] jump_addr = '0;
  logic [31:0] pc_out, iw_out;
  logic        misalign_out;
  rv32i_fetch_unit_if imem();
  rv32i_fetch_unit #(.RESET_PC(RST_PC), .DEPTH(2), .NOP(NOP)) dut (
    .clk(clk), .reset(reset), .jump_enable(jump_enable), .jump_addr(jump_addr), .stall(stall),
    .imem(imem), .pc_out(pc_out), .iw_out(iw_out), .misalign_out(misalign_out));
  always #5 clk = ~clk;
  typedef struct { logic [31:0] addr; int due; } mreq_t;
  mreq_t       mq[$];
  logic [31:0] exp_q[$];
  int          cyc = 0, errors = 0, checks = 0, dcount = 0, gnt_pct = 100, lat_min = 1, lat_max = 1;
  logic        s_reset = 1'b1, s_jump = 1'b0, s_stall = 1'b0, s_mis = 1'b0;
  logic [31:0] prev_pc, prev_iw, exp_pc;
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at cycle %0d", name, act, exp, cyc);
    end
  endtask
  // aligned addresses map to words ending in 2'b10, so memory data never equals the NOP bubble
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a ^ 32'h5A5A_0000) | 32'h2;
  endfunction
  task automatic reload(input logic [31:0] base);
    exp_q.delete();
    for (int i = 0; i < 8; i++) exp_q.push_back(base + 32'(4 * i));
  endtask
  always @(posedge clk) begin
    cyc++;
    s_reset = reset;
    s_jump  = jump_enable;
    s_stall = stall;
    s_mis   = jump_enable && (jump_addr[1:0] != 2'b00);
    if (imem.rvalid === 1'b1 && mq.size() > 0) void'(mq.pop_front());
    if (reset) mq.delete();
    else if (imem.req === 1'b1 && imem.gnt === 1'b1)
      mq.push_back('{imem.addr, cyc + int'($urandom_range(lat_max, lat_min)) - 1});
    if (reset) reload(RST_PC);
    else if (jump_enable) reload({jump_addr[31:2], 2'b00});
    else if (exp_q.size() < 8) exp_q.push_back(exp_q[$] + 32'd4);
  end
  always @(negedge clk) begin
    imem.gnt = $urandom_range(99) < gnt_pct;
    if (mq.size() > 0 && mq[0].due <= cyc) begin
      imem.rvalid = 1'b1;
      imem.rdata  = mem_word(mq[0].addr);
    end else begin
      imem.rvalid = 1'b0;
      imem.rdata  = $urandom;
    end
  end
  always @(negedge clk) begin
    if (cyc > 0) begin
      if (s_reset) begin
        chk("rst_pc", pc_out, RST_PC);
        chk("rst_iw", iw_out, NOP);
        chk("rst_mis", 32'(misalign_out), 32'd0);
      end else if (s_jump) begin
        chk("jump_nop", iw_out, NOP);
        chk("jump_pc_hold", pc_out, prev_pc);
        chk("jump_mis", 32'(misalign_out), 32'(s_mis));
      end else begin
        chk("mis_idle", 32'(misalign_out), 32'd0);
        if (s_stall) begin
          chk("stall_pc", pc_out, prev_pc);
          chk("stall_iw", iw_out, prev_iw);
        end else if (iw_out !== NOP) begin
          exp_pc = exp_q.pop_front();
          chk("sb_pc", pc_out, exp_pc);
          chk("sb_iw", iw_out, mem_word(exp_pc));
          dcount++;
        end else chk("bubble_pc_hold", pc_out, prev_pc);
      end
      chk("buf_bound", 32'(dut.buf_cnt > 2), 32'd0);
    end
    prev_pc = pc_out;
    prev_iw = iw_out;
  end
  task automatic do_jump(input logic [31:0] a);
    @(negedge clk);
    jump_enable = 1'b1;
    jump_addr   = a;
    @(negedge clk);
    jump_enable = 1'b0;
    #1;
    chk("jump_target_addr", imem.addr, {a[31:2], 2'b00});
  endtask
  initial begin
    int d0;
    repeat (3) @(negedge clk);
    chk("req_in_reset", 32'(imem.req), 32'd0);
    reset = 1'b0;
    #1;
    chk("first_req", 32'(imem.req), 32'd1);
    chk("first_addr", imem.addr, RST_PC);
    repeat (2) @(negedge clk);
    #1;
    chk("latency_pc", pc_out, RST_PC);
    d0 = dcount;
    repeat (20) begin
      @(negedge clk);
      #1;
      chk("seq_req_high", 32'(imem.req), 32'd1);
    end
    chk("throughput", 32'(dcount - d0), 32'd20);
    @(negedge clk);
    stall = 1'b1;
    repeat (2) @(negedge clk);
    #1;
    chk("stall_req_drop", 32'(imem.req), 32'd0);
    @(negedge clk);
    stall = 1'b0;
    #1;
    d0 = dcount;
    repeat (4) @(negedge clk);
    #1;
    chk("stall_release", 32'(dcount - d0), 32'd4);
    lat_min = 2;
    lat_max = 2;
    repeat (8) @(negedge clk);
    d0 = dcount;
    do_jump(32'h100);
    repeat (12) @(negedge clk);
    #1;
    chk("inflight_progress", 32'(dcount - d0 >= 3), 32'd1);
    lat_min = 1;
    lat_max = 1;
    repeat (6) @(negedge clk);
    do_jump(32'h203);
    chk("mis_pulse", 32'(misalign_out), 32'd1);
    chk("zw_jump_req", 32'(imem.req), 32'd1);
    @(negedge clk);
    #1;
    chk("mis_clear", 32'(misalign_out), 32'd0);
    @(negedge clk);
    #1;
    chk("target_latency_pc", pc_out, 32'h200);
    chk("target_latency_iw", iw_out, mem_word(32'h200));
    repeat (4) @(negedge clk);
    stall = 1'b1;
    @(negedge clk);
    do_jump(32'h400);
    chk("stall_jump_nop", iw_out, NOP);
    chk("stall_jump_buf", 32'(dut.buf_cnt), 32'd0);
    repeat (2) @(negedge clk);
    stall = 1'b0;
    d0 = dcount;
    repeat (8) @(negedge clk);
    #1;
    chk("stall_jump_progress", 32'(dcount - d0 >= 3), 32'd1);
    lat_min = 2;
    lat_max = 2;
    repeat (6) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    #1;
    chk("mid_rst_pc", pc_out, RST_PC);
    chk("mid_rst_iw", iw_out, NOP);
    reset = 1'b0;
    #1;
    chk("restart_req", 32'(imem.req), 32'd1);
    chk("restart_addr", imem.addr, RST_PC);
    lat_min = 1;
    lat_max = 1;
    repeat (10) @(negedge clk);
    do_jump(32'hFFFF_FFFC);
    chk("wrap_req", 32'(imem.req), 32'd1);
    @(negedge clk);
    #1;
    chk("wrap_addr", imem.addr, 32'h0);
    repeat (6) @(negedge clk);
    gnt_pct = 70;
    lat_max = 3;
    d0 = dcount;
    repeat (1500) begin
      @(negedge clk);
      stall       = $urandom_range(99) < 30;
      jump_enable = $urandom_range(99) < 5;
      jump_addr   = ($urandom_range(3) == 0) ? 32'hFFFF_FFF0 + ($urandom & 32'hF) : $urandom;
      reset       = $urandom_range(999) < 5;
    end
    @(negedge clk);
    reset       = 1'b0;
    stall       = 1'b0;
    jump_enable = 1'b0;
    gnt_pct     = 100;
    lat_max     = 1;
    repeat (20) @(negedge clk);
    #1;
    chk("random_progress", 32'(dcount - d0 > 200), 32'd1);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
